// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  localparam logic [2:0] MEM_SIZE_WORD = 3'd2;

  // Width of a counter that must hold values 0..max_streak (at least 1 bit).
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant decision between instruction and data requesters. Data side wins
// unless the instruction side has watched MAX_D_STREAK data grants in a row.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic                ireq_valid_i,
  input  logic                dreq_valid_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_any_o,
  output arb_src_t            grant_src_o
);

  logic force_i;

  assign force_i = (MAX_D_STREAK != 0) && (streak_i == STREAK_W'(MAX_D_STREAK));

  // Data side by default; ibus only when alone or when the guard trips.
  always_comb begin
    grant_any_o = ireq_valid_i | dreq_valid_i;
    grant_src_o = SRC_D;
    if (ireq_valid_i && !dreq_valid_i) begin
      grant_src_o = SRC_I;
    end else if (ireq_valid_i && dreq_valid_i && force_i) begin
      grant_src_o = SRC_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between the CPU instruction and data
// buses. One transaction in flight; request fields are latched at grant.
//
// state | meaning
// IDLE  | sample ireq/dreq, grant one and latch its fields
// ISSUE | creq_valid high, waiting for creq_ready
// WAIT  | request accepted, waiting for cresp_valid
// RESP  | one-cycle data_ok pulse to the granted requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_data_ok,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                creq_ready,
  input  logic                cresp_valid,
  input  logic [DATA_W-1:0]   cresp_data
);

  localparam int STREAK_W = streak_width(MAX_D_STREAK);

  arb_state_t            state_q;
  arb_src_t              src_q;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  creq_valid_q;
  logic [ADDR_W-1:0]     creq_addr_q;
  logic [2:0]            creq_size_q;
  logic [DATA_W/8-1:0]   creq_strobe_q;
  logic [DATA_W-1:0]     creq_data_q;
  logic [DATA_W-1:0]     resp_q;
  logic                  iresp_ok_q;
  logic                  dresp_ok_q;

  logic                  grant_any;
  arb_src_t              grant_src;

  arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_pick (
    .ireq_valid_i (ireq_valid),
    .dreq_valid_i (dreq_valid),
    .streak_i     (streak_q),
    .grant_any_o  (grant_any),
    .grant_src_o  (grant_src)
  );

  // Streak counts data grants made while a fetch was left waiting.
  always_comb begin
    streak_d = streak_q;
    if (grant_src == SRC_I || !ireq_valid) begin
      streak_d = '0;
    end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Transaction FSM with registered downstream and response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      src_q         <= SRC_I;
      streak_q      <= '0;
      creq_valid_q  <= 1'b0;
      creq_addr_q   <= '0;
      creq_size_q   <= '0;
      creq_strobe_q <= '0;
      creq_data_q   <= '0;
      resp_q        <= '0;
      iresp_ok_q    <= 1'b0;
      dresp_ok_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q      <= ISSUE;
            src_q        <= grant_src;
            streak_q     <= streak_d;
            creq_valid_q <= 1'b1;
            if (grant_src == SRC_I) begin
              creq_addr_q   <= ireq_addr;
              creq_size_q   <= MEM_SIZE_WORD;
              creq_strobe_q <= '0;
              creq_data_q   <= '0;
            end else begin
              creq_addr_q   <= dreq_addr;
              creq_size_q   <= dreq_size;
              creq_strobe_q <= dreq_strobe;
              creq_data_q   <= dreq_data;
            end
          end
        end
        ISSUE: begin
          if (creq_ready) begin
            creq_valid_q <= 1'b0;
            if (cresp_valid) begin
              state_q    <= RESP;
              resp_q     <= cresp_data;
              iresp_ok_q <= (src_q == SRC_I);
              dresp_ok_q <= (src_q == SRC_D);
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cresp_valid) begin
            state_q    <= RESP;
            resp_q     <= cresp_data;
            iresp_ok_q <= (src_q == SRC_I);
            dresp_ok_q <= (src_q == SRC_D);
          end
        end
        RESP: begin
          state_q    <= IDLE;
          iresp_ok_q <= 1'b0;
          dresp_ok_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign creq_valid    = creq_valid_q;
  assign creq_addr     = creq_addr_q;
  assign creq_size     = creq_size_q;
  assign creq_strobe   = creq_strobe_q;
  assign creq_data     = creq_data_q;
  assign iresp_data_ok = iresp_ok_q;
  assign dresp_data_ok = dresp_ok_q;
  assign iresp_data    = resp_q;
  assign dresp_data    = resp_q;

`ifndef SYNTHESIS
  // Flag responses arriving when no accepted request is outstanding.
  always_ff @(posedge clk) begin
    if (resetn && cresp_valid &&
        (state_q == IDLE || state_q == RESP || (state_q == ISSUE && !creq_ready))) begin
      $error("mem_port_arbiter: cresp_valid with no accepted request (state %0d)", state_q);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, dbus priority, starvation
// guard, backpressure, delayed response and asynchronous reset in WAIT.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        creq_valid;
  logic [31:0] creq_addr;
  logic [2:0]  creq_size;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic        creq_ready;
  logic        cresp_valid;
  logic [31:0] cresp_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .creq_valid    (creq_valid),
    .creq_addr     (creq_addr),
    .creq_size     (creq_size),
    .creq_strobe   (creq_strobe),
    .creq_data     (creq_data),
    .creq_ready    (creq_ready),
    .cresp_valid   (cresp_valid),
    .cresp_data    (cresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    creq_ready  = 1'b0;
    cresp_valid = 1'b0;
    cresp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_creq_valid", 64'(creq_valid), 64'd0);
    check("rst_creq_addr", 64'(creq_addr), 64'd0);
    check("rst_iresp_ok", 64'(iresp_data_ok), 64'd0);
    check("rst_dresp_ok", 64'(dresp_data_ok), 64'd0);
    check("rst_iresp_data", 64'(iresp_data), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    resetn = 1'b1;
    tick();

    // Single fetch, zero-wait downstream.
    ireq_valid = 1'b1;
    ireq_addr  = 32'hBFC0_0000;
    tick();
    check("t1_creq_valid", 64'(creq_valid), 64'd1);
    check("t1_creq_addr", 64'(creq_addr), 64'hBFC0_0000);
    check("t1_creq_size", 64'(creq_size), 64'd2);
    check("t1_creq_strobe", 64'(creq_strobe), 64'd0);
    creq_ready  = 1'b1;
    cresp_valid = 1'b1;
    cresp_data  = 32'h2402_0001;
    tick();
    check("t1_iresp_ok", 64'(iresp_data_ok), 64'd1);
    check("t1_iresp_data", 64'(iresp_data), 64'h2402_0001);
    check("t1_dresp_ok", 64'(dresp_data_ok), 64'd0);
    check("t1_creq_valid_off", 64'(creq_valid), 64'd0);
    ireq_valid  = 1'b0;
    creq_ready  = 1'b0;
    cresp_valid = 1'b0;
    tick();
    check("t1_iresp_ok_pulse", 64'(iresp_data_ok), 64'd0);

    // Both valid: dbus first, then ibus.
    ireq_valid  = 1'b1;
    ireq_addr   = 32'h0000_1000;
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h0000_2000;
    dreq_size   = 3'd2;
    dreq_strobe = 4'hF;
    dreq_data   = 32'hDEAD_BEEF;
    tick();
    check("t2_d_addr", 64'(creq_addr), 64'h2000);
    check("t2_d_strobe", 64'(creq_strobe), 64'hF);
    check("t2_d_data", 64'(creq_data), 64'hDEAD_BEEF);
    check("t2_streak1", 64'(dut.streak_q), 64'd1);
    creq_ready  = 1'b1;
    cresp_valid = 1'b1;
    cresp_data  = 32'h0;
    tick();
    check("t2_dresp_ok", 64'(dresp_data_ok), 64'd1);
    check("t2_iresp_ok", 64'(iresp_data_ok), 64'd0);
    dreq_valid  = 1'b0;
    creq_ready  = 1'b0;
    cresp_valid = 1'b0;
    tick();
    check("t2_idle_creq_valid", 64'(creq_valid), 64'd0);
    tick();
    check("t2_i_addr", 64'(creq_addr), 64'h1000);
    check("t2_i_strobe", 64'(creq_strobe), 64'd0);
    check("t2_i_data", 64'(creq_data), 64'd0);
    check("t2_i_size", 64'(creq_size), 64'd2);
    check("t2_streak0", 64'(dut.streak_q), 64'd0);
    creq_ready = 1'b1;
    tick();
    check("t2_wait_creq_valid", 64'(creq_valid), 64'd0);
    creq_ready  = 1'b0;
    cresp_valid = 1'b1;
    cresp_data  = 32'hCAFE_F00D;
    tick();
    check("t2_iresp_ok", 64'(iresp_data_ok), 64'd1);
    check("t2_iresp_data", 64'(iresp_data), 64'hCAFE_F00D);
    ireq_valid  = 1'b0;
    cresp_valid = 1'b0;
    tick();

    // Starvation guard: four dbus grants, then ibus.
    ireq_valid  = 1'b1;
    ireq_addr   = 32'h0000_6000;
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h0000_7000;
    dreq_size   = 3'd2;
    dreq_strobe = 4'h0;
    dreq_data   = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_addr_%0d", k), 64'(creq_addr), (k < 4) ? 64'h7000 : 64'h6000);
      creq_ready  = 1'b1;
      cresp_valid = 1'b1;
      cresp_data  = 32'(k);
      tick();
      check($sformatf("t3_iok_%0d", k), 64'(iresp_data_ok), (k == 4) ? 64'd1 : 64'd0);
      check($sformatf("t3_dok_%0d", k), 64'(dresp_data_ok), (k < 4) ? 64'd1 : 64'd0);
      creq_ready  = 1'b0;
      cresp_valid = 1'b0;
      if (k == 4) begin
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
      end
      tick();
    end
    check("t3_streak_after", 64'(dut.streak_q), 64'd0);

    // Backpressure for five cycles, then a seven-cycle response delay.
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h0000_3000;
    dreq_size   = 3'd0;
    dreq_strobe = 4'h0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_valid_%0d", k), 64'(creq_valid), 64'd1);
      check($sformatf("t4_addr_%0d", k), 64'(creq_addr), 64'h3000);
      tick();
    end
    creq_ready = 1'b1;
    check("t4_valid_5", 64'(creq_valid), 64'd1);
    check("t4_addr_5", 64'(creq_addr), 64'h3000);
    check("t4_size_5", 64'(creq_size), 64'd0);
    tick();
    creq_ready = 1'b0;
    check("t4_wait_valid", 64'(creq_valid), 64'd0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t5_dok_idle_%0d", k), 64'(dresp_data_ok), 64'd0);
      tick();
    end
    cresp_valid = 1'b1;
    cresp_data  = 32'h1234_5678;
    tick();
    check("t5_dresp_ok", 64'(dresp_data_ok), 64'd1);
    check("t5_dresp_data", 64'(dresp_data), 64'h1234_5678);
    cresp_valid = 1'b0;
    dreq_valid  = 1'b0;
    tick();
    check("t5_dresp_ok_pulse", 64'(dresp_data_ok), 64'd0);
    check("t5_dresp_hold1", 64'(dresp_data), 64'h1234_5678);
    tick();
    check("t5_dresp_hold2", 64'(dresp_data), 64'h1234_5678);
    check("t4_single_txn", 64'(creq_valid), 64'd0);

    // Asynchronous reset while in WAIT.
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h0000_4000;
    dreq_size   = 3'd2;
    dreq_strobe = 4'h3;
    dreq_data   = 32'h0000_55AA;
    tick();
    creq_ready = 1'b1;
    tick();
    creq_ready = 1'b0;
    dreq_valid = 1'b0;
    check("t6_in_wait", 64'(dut.state_q), 64'(WAIT));
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_addr", 64'(creq_addr), 64'd0);
    check("t6_rst_strobe", 64'(creq_strobe), 64'd0);
    check("t6_rst_dresp_data", 64'(dresp_data), 64'd0);
    check("t6_rst_state", 64'(dut.state_q), 64'(IDLE));
    #2;
    resetn = 1'b1;
    tick();
    check("t6_post_state", 64'(dut.state_q), 64'(IDLE));
    check("t6_post_streak", 64'(dut.streak_q), 64'd0);
    ireq_valid = 1'b1;
    ireq_addr  = 32'h0000_5000;
    tick();
    check("t6_next_addr", 64'(creq_addr), 64'h5000);
    check("t6_next_valid", 64'(creq_valid), 64'd1);
    creq_ready  = 1'b1;
    cresp_valid = 1'b1;
    cresp_data  = 32'hAABB_CCDD;
    tick();
    check("t6_next_iok", 64'(iresp_data_ok), 64'd1);
    check("t6_next_idata", 64'(iresp_data), 64'hAABB_CCDD);
    ireq_valid  = 1'b0;
    creq_ready  = 1'b0;
    cresp_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
